// File: rtl/csi_vc_arbiter.sv
// Packet-level round-robin arbiter: N_SRC virtual-channel sources share one
// protocol-layer packet input, with a programmable idle gap after each packet.
module csi_vc_arbiter #(
    parameter int N_SRC      = 4,
    parameter int DATA_W     = 32,
    parameter int GAP_CYCLES = 8,
    parameter int VC_W       = $clog2(N_SRC)
) (
    input  logic                      hs_clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [N_SRC-1:0]          src_valid,
    input  logic [N_SRC*DATA_W-1:0]   src_data,
    input  logic [N_SRC-1:0]          src_last,
    output logic [N_SRC-1:0]          src_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_last,
    output logic [VC_W-1:0]           out_vc,
    input  logic                      out_ready,
    output logic [N_SRC-1:0]          grant,
    output logic                      busy
);

    // A GAP_CYCLES of 0 would give a zero-width counter; keep at least one bit.
    localparam int CNT_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [VC_W-1:0]   ptr;
    logic [VC_W-1:0]   ptr_nxt;
    logic [VC_W-1:0]   vc_nxt;
    logic [N_SRC-1:0]  grant_nxt;
    logic [CNT_W-1:0]  gap_cnt;
    logic [CNT_W-1:0]  gap_cnt_nxt;
    logic              win_found;
    logic [VC_W-1:0]   win_idx;
    logic              in_xfer;
    logic              beat_fire;
    logic              pkt_done;

    // Round-robin search: first requester at or after ptr+1 (mod N_SRC) wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 1; i <= N_SRC; i++) begin
            automatic int idx = (int'(ptr) + i) % N_SRC;
            if (!win_found && src_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = VC_W'(idx);
            end
        end
    end

    // Handshake: a beat moves on any edge where out_valid && out_ready are both
    // high; out_valid never waits on out_ready, and src_ready of the granted
    // source is exactly out_ready, so the source side sees the same rule.
    assign in_xfer   = (state == XFER);
    assign out_valid = in_xfer & src_valid[out_vc];
    assign out_last  = in_xfer & src_last[out_vc];
    assign out_data  = in_xfer ? src_data[int'(out_vc)*DATA_W +: DATA_W] : '0;
    assign src_ready = (in_xfer && out_ready) ? grant : '0;
    assign busy      = (state != IDLE);

    assign beat_fire = out_valid & out_ready;
    assign pkt_done  = beat_fire & out_last;

    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        vc_nxt      = out_vc;
        ptr_nxt     = ptr;
        gap_cnt_nxt = gap_cnt;
        case (state)
            IDLE: begin
                if (enable && win_found) begin
                    grant_nxt          = '0;
                    grant_nxt[win_idx] = 1'b1;
                    vc_nxt             = win_idx;
                    state_nxt          = XFER;
                end
            end
            XFER: begin
                if (pkt_done) begin
                    grant_nxt = '0;
                    ptr_nxt   = out_vc;
                    if (GAP_CYCLES == 0) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt   = GAP;
                        gap_cnt_nxt = CNT_W'(GAP_CYCLES - 1);
                    end
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    // ptr starts at the top index so that source 0 is searched first.
    always_ff @(posedge hs_clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            grant   <= '0;
            out_vc  <= '0;
            ptr     <= VC_W'(N_SRC - 1);
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            out_vc  <= vc_nxt;
            ptr     <= ptr_nxt;
            gap_cnt <= gap_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_csi_vc_arbiter.sv
// Bench for csi_vc_arbiter: queue-backed source models, a beat scoreboard,
// and directed scenarios for ordering, stalls, enable, reset and zero gap.
module tb_csi_vc_arbiter;

    localparam int N = 4;
    localparam int W = 32;
    localparam int G = 8;

    logic             hs_clk    = 1'b0;
    logic             rst       = 1'b1;
    logic             enable    = 1'b0;
    logic [N-1:0]     src_valid = '0;
    logic [N*W-1:0]   src_data  = '0;
    logic [N-1:0]     src_last  = '0;
    logic [N-1:0]     src_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic             out_last;
    logic [1:0]       out_vc;
    logic             out_ready = 1'b1;
    logic [N-1:0]     grant;
    logic             busy;

    logic             b_enable    = 1'b1;
    logic [1:0]       b_valid     = '0;
    logic [2*W-1:0]   b_data      = {32'h0000_00B1, 32'h0000_00B0};
    logic [1:0]       b_last      = 2'b11;
    logic [1:0]       b_ready;
    logic             b_out_valid;
    logic [W-1:0]     b_out_data;
    logic             b_out_last;
    logic             b_out_vc;
    logic             b_out_ready = 1'b1;
    logic [1:0]       b_grant;
    logic             b_busy;

    always #5 hs_clk = ~hs_clk;

    csi_vc_arbiter #(.N_SRC(N), .DATA_W(W), .GAP_CYCLES(G)) dut (
        .hs_clk(hs_clk), .rst(rst), .enable(enable),
        .src_valid(src_valid), .src_data(src_data), .src_last(src_last),
        .src_ready(src_ready), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_vc(out_vc), .out_ready(out_ready),
        .grant(grant), .busy(busy)
    );

    csi_vc_arbiter #(.N_SRC(2), .DATA_W(W), .GAP_CYCLES(0)) dut_b (
        .hs_clk(hs_clk), .rst(rst), .enable(b_enable),
        .src_valid(b_valid), .src_data(b_data), .src_last(b_last),
        .src_ready(b_ready), .out_valid(b_out_valid), .out_data(b_out_data),
        .out_last(b_out_last), .out_vc(b_out_vc), .out_ready(b_out_ready),
        .grant(b_grant), .busy(b_busy)
    );

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    logic [W:0]       src_q [N][$];
    logic [N-1:0]     hold = '0;
    logic [N-1:0]     fire = '0;
    logic [W+2:0]     exp_q[$];
    logic [W:0]       expb_q[$];
    int               order_q[$];
    int               space_q[$];
    int               len_q[$];
    bit               in_pkt   = 1'b0;
    bit               have_last = 1'b0;
    int               last_cyc = 0;
    int               start_cyc = 0;
    bit               b_have   = 1'b0;
    int               b_last_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [W-1:0] mk(input int s, input int p, input int b);
        mk = 32'hA000_0000 | 32'(s << 16) | 32'(p << 8) | 32'(b);
    endfunction

    task automatic load_pkt(input int s, input int p, input int n);
        for (int b = 0; b < n; b++) src_q[s].push_back({(b == n - 1), mk(s, p, b)});
    endtask

    task automatic expect_pkt(input int s, input int p, input int n);
        for (int b = 0; b < n; b++) exp_q.push_back({2'(s), (b == n - 1), mk(s, p, b)});
    endtask

    task automatic clear_mon();
        order_q.delete();
        space_q.delete();
        len_q.delete();
        in_pkt    = 1'b0;
        have_last = 1'b0;
    endtask

    task automatic drive_sources();
        logic [W:0] h;
        for (int i = 0; i < N; i++) begin
            if (fire[i] && src_q[i].size() > 0) h = src_q[i].pop_front();
            if (src_q[i].size() > 0 && !hold[i]) begin
                h = src_q[i][0];
                src_valid[i]          = 1'b1;
                src_last[i]           = h[W];
                src_data[i*W +: W]    = h[W-1:0];
            end else begin
                src_valid[i] = 1'b0;
                src_last[i]  = 1'b0;
            end
        end
    endtask

    task automatic monitor_a();
        logic [W+2:0] e;
        fire = src_valid & src_ready;
        chk("ready_only_granted", 64'(src_ready & ~grant), 64'd0);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_beat: got vc %0d data %0h, no beat expected", out_vc, out_data);
            end else begin
                e = exp_q.pop_front();
                chk("beat", 64'({out_vc, out_last, out_data}), 64'(e));
            end
            if (!in_pkt) begin
                order_q.push_back(int'(out_vc));
                start_cyc = cyc;
                if (have_last) space_q.push_back(cyc - last_cyc);
            end
            if (out_last) begin
                len_q.push_back(cyc - start_cyc + 1);
                in_pkt    = 1'b0;
                have_last = 1'b1;
                last_cyc  = cyc;
            end else begin
                in_pkt = 1'b1;
            end
        end
    endtask

    task automatic monitor_b();
        logic [W:0] e;
        if (b_out_valid && b_out_ready) begin
            if (expb_q.size() == 0) begin
                checks++;
                $display("FAIL t6_unexpected_beat: got vc %0d data %0h", b_out_vc, b_out_data);
            end else begin
                e = expb_q.pop_front();
                chk("t6_beat", 64'({b_out_vc, b_out_data}), 64'(e));
            end
            if (b_have) chk("t6_spacing", 64'(cyc - b_last_cyc), 64'd2);
            b_have     = 1'b1;
            b_last_cyc = cyc;
        end
    endtask

    initial forever begin
        @(posedge hs_clk);
        cyc++;
    end

    initial forever begin
        @(posedge hs_clk);
        #2;
        drive_sources();
    end

    initial forever begin
        @(negedge hs_clk);
        monitor_a();
        monitor_b();
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", passes, checks);
        $fatal(1);
    end

    task automatic wait_drain(input string name);
        for (int i = 0; i < 300; i++) begin
            @(posedge hs_clk);
            if (exp_q.size() == 0) break;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            @(negedge hs_clk);
            if (!busy) break;
        end
        chk("wait_idle", 64'(busy), 64'd0);
        @(posedge hs_clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge hs_clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < N; i++) src_q[i].delete();
        exp_q.delete();
        hold      = '0;
        out_ready = 1'b1;
        enable    = 1'b1;
        clear_mon();
        repeat (2) @(posedge hs_clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk_order(input string name, input int n, input int e0, input int e1,
                             input int e2, input int e3, input int e4);
        int exp_o[5];
        exp_o = '{e0, e1, e2, e3, e4};
        chk({name, "_count"}, 64'(order_q.size()), 64'(n));
        for (int i = 0; i < n; i++)
            chk(name, 64'((i < order_q.size()) ? order_q[i] : 99), 64'(exp_o[i]));
    endtask

    initial begin
        int gap_busy;
        int gap_valid;

        // Reset values while rst is held.
        repeat (3) @(posedge hs_clk);
        #1;
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_vc", 64'(out_vc), 64'd0);
        chk("rst_src_ready", 64'(src_ready), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        rst    = 1'b0;
        enable = 1'b1;

        // Single 3-beat packet from source 0, then an 8-cycle gap.
        @(posedge hs_clk);
        #1;
        clear_mon();
        load_pkt(0, 0, 3);
        expect_pkt(0, 0, 3);
        @(negedge hs_clk);
        chk("t1_no_grant_yet", 64'(grant), 64'd0);
        @(negedge hs_clk);
        chk("t1_grant", 64'(grant), 64'b0001);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_vc", 64'(out_vc), 64'd0);
        wait_drain("t1_drain");
        gap_busy  = 0;
        gap_valid = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge hs_clk);
            if (!busy) break;
            gap_busy++;
            if (out_valid) gap_valid++;
        end
        chk("t1_gap_cycles", 64'(gap_busy), 64'd8);
        chk("t1_gap_valid", 64'(gap_valid), 64'd0);
        chk("t1_len", 64'((len_q.size() > 0) ? len_q[0] : 0), 64'd3);

        // All four sources request; source 0 has two packets queued.
        do_reset();
        load_pkt(0, 0, 2);
        load_pkt(0, 1, 2);
        load_pkt(1, 0, 2);
        load_pkt(2, 0, 2);
        load_pkt(3, 0, 2);
        expect_pkt(0, 0, 2);
        expect_pkt(1, 0, 2);
        expect_pkt(2, 0, 2);
        expect_pkt(3, 0, 2);
        expect_pkt(0, 1, 2);
        wait_drain("t2_drain");
        chk_order("t2_order", 5, 0, 1, 2, 3, 0);
        chk("t2_space_count", 64'(space_q.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            chk("t2_spacing", 64'((i < space_q.size()) ? space_q[i] : 0), 64'd10);
        for (int i = 0; i < 5; i++)
            chk("t2_len", 64'((i < len_q.size()) ? len_q[i] : 0), 64'd2);

        // Source 2 with out_ready toggling and a 2-cycle valid drop.
        wait_idle();
        load_pkt(2, 0, 4);
        expect_pkt(2, 0, 4);
        for (int i = 0; i < 12; i++) begin
            @(posedge hs_clk);
            #1;
            out_ready = (i % 2 == 0);
            hold[2]   = (i == 3 || i == 4);
            if (hold[2]) begin
                @(negedge hs_clk);
                chk("t3_grant_held", 64'(grant), 64'b0100);
                chk("t3_valid_follows", 64'(out_valid), 64'd0);
            end
        end
        out_ready = 1'b1;
        hold      = '0;
        wait_drain("t3_drain");

        // enable drops during beat 2 of a 4-beat packet from source 1.
        wait_idle();
        do_reset();
        load_pkt(1, 0, 4);
        expect_pkt(1, 0, 4);
        @(posedge hs_clk);
        #1;
        load_pkt(0, 1, 1);
        load_pkt(2, 1, 1);
        load_pkt(3, 1, 1);
        @(posedge hs_clk);
        #1;
        enable = 1'b0;
        wait_drain("t4_drain_a");
        repeat (15) @(negedge hs_clk);
        chk("t4_no_grant", 64'(grant), 64'd0);
        chk("t4_idle", 64'(busy), 64'd0);
        clear_mon();
        expect_pkt(2, 1, 1);
        expect_pkt(3, 1, 1);
        expect_pkt(0, 1, 1);
        @(posedge hs_clk);
        #1;
        enable = 1'b1;
        @(negedge hs_clk);
        chk("t4_grant_wait", 64'(grant), 64'd0);
        @(negedge hs_clk);
        chk("t4_grant_src2", 64'(grant), 64'b0100);
        wait_drain("t4_drain_b");
        chk_order("t4_order", 3, 2, 3, 0, 0, 0);

        // Reset pulse during beat 2 of a packet from source 3.
        wait_idle();
        clear_mon();
        load_pkt(3, 0, 4);
        exp_q.push_back({2'd3, 1'b0, mk(3, 0, 0)});
        @(posedge hs_clk);
        #1;
        @(posedge hs_clk);
        #1;
        rst = 1'b1;
        #2;
        chk("t5_grant", 64'(grant), 64'd0);
        chk("t5_out_valid", 64'(out_valid), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_out_vc", 64'(out_vc), 64'd0);
        chk("t5_src_ready", 64'(src_ready), 64'd0);
        chk("t5_out_last", 64'(out_last), 64'd0);
        chk("t5_out_data", 64'(out_data), 64'd0);
        chk("t5_beat1_seen", 64'(exp_q.size()), 64'd0);
        src_q[3].delete();
        clear_mon();
        load_pkt(3, 1, 1);
        load_pkt(1, 1, 1);
        expect_pkt(1, 1, 1);
        expect_pkt(3, 1, 1);
        @(posedge hs_clk);
        #1;
        rst = 1'b0;
        wait_drain("t5_drain");
        chk_order("t5_order", 2, 1, 3, 0, 0, 0);

        // Zero-gap instance: two sources, single-beat packets.
        wait_idle();
        expb_q.push_back({1'b0, 32'h0000_00B0});
        expb_q.push_back({1'b1, 32'h0000_00B1});
        expb_q.push_back({1'b0, 32'h0000_00B0});
        expb_q.push_back({1'b1, 32'h0000_00B1});
        b_valid = 2'b11;
        for (int i = 0; i < 50; i++) begin
            @(posedge hs_clk);
            if (expb_q.size() == 0) break;
        end
        #1;
        b_valid = 2'b00;
        chk("t6_drain", 64'(expb_q.size()), 64'd0);
        repeat (4) @(posedge hs_clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
